// File: rtl/intc_irq_responder.sv
// IRQ/IACK responder: takes an interrupt at a safe boundary, saves the return PC and redirects fetch.
// Optional `irq` release watchdog is built when INTC_RESP_TIMEOUT_EN is defined.
module intc_irq_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  irq,
    input  logic [ADDR_WIDTH-1:0] isr_addr,
    input  logic                  int_en,
    input  logic                  boundary,
    input  logic [ADDR_WIDTH-1:0] cur_pc,
    input  logic                  iret,
    output logic                  iack,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  in_service,
    output logic                  timeout_err,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_DROP = 2'd2,
        SERVICE   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t state;
    state_t state_next;
    logic   take;
    logic   timeout_hit;

    assign take      = irq & int_en & boundary;
    assign fsm_state = state;

`ifdef INTC_RESP_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts WAIT_DROP cycles with irq still high; the hit cycle is the one that would reach the limit.
    assign timeout_hit = (state == WAIT_DROP) && irq && ((wait_cnt + 8'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ACK) begin
                wait_cnt <= 8'd0;
            end else if (state == WAIT_DROP && irq) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic [7:0] unused_timeout_limit;

    assign unused_timeout_limit = TIMEOUT_LIMIT;
    assign timeout_hit          = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!irq || timeout_hit) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (iret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            iack           <= 1'b0;
            redirect_valid <= 1'b0;
            in_service     <= 1'b0;
            redirect_pc    <= '0;
            epc            <= '0;
        end else begin
            state          <= state_next;
            iack           <= (state_next == ACK);
            redirect_valid <= (state_next == ACK);
            in_service     <= (state_next != IDLE);
            if (state == IDLE && take) begin
                redirect_pc <= isr_addr;
                epc         <= cur_pc;
            end
        end
    end

endmodule
